serial_dot_product: RTL and testbench



---
 rtl/serial_dot_product_pkg.sv | 15 +
 rtl/sdp_mul_ext.sv | 45 ++++
 rtl/serial_dot_product.sv | 131 +++++++++++++
 tb/tb_serial_dot_product.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_dot_product_pkg.sv
// Shared types and width helpers for the serial dot-product engine.
package serial_dot_product_pkg;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    MAC_B  = 2'd1,
    OUT    = 2'd2
  } sdp_state_t;

  // Result width wide enough to hold LEN full-scale products without wrap.
  function automatic int unsigned out_width(input int unsigned data_w, input int unsigned len);
    return (2 * data_w) + 32'($clog2(len + 1));
  endfunction

endpackage

// File: rtl/sdp_mul_ext.sv
// Single DATA_W x DATA_W multiplier, extended to the accumulator width.
module sdp_mul_ext
  import serial_dot_product_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SIGNED = 0,
  parameter int unsigned OUT_W  = 18
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [OUT_W-1:0]  p_c
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned EXT_W  = OUT_W - PROD_W;

  generate
    if (SIGNED != 0) begin : g_signed
      logic signed [PROD_W-1:0] a_ext;
      logic signed [PROD_W-1:0] b_ext;
      logic signed [PROD_W-1:0] prod;

      // Two's complement product, sign-extended into the accumulator width.
      always_comb begin
        a_ext = PROD_W'($signed(a));
        b_ext = PROD_W'($signed(b));
        prod  = a_ext * b_ext;
        p_c   = {{EXT_W{prod[PROD_W-1]}}, prod};
      end
    end else begin : g_unsigned
      logic [PROD_W-1:0] a_ext;
      logic [PROD_W-1:0] b_ext;
      logic [PROD_W-1:0] prod;

      // Unsigned product, zero-extended into the accumulator width.
      always_comb begin
        a_ext = PROD_W'(a);
        b_ext = PROD_W'(b);
        prod  = a_ext * b_ext;
        p_c   = {{EXT_W{1'b0}}, prod};
      end
    end
  endgenerate

endmodule

// File: rtl/serial_dot_product.sv
// Serial dot-product engine: buffers a[], then multiply-accumulates against b[]
// as it streams in, and holds the result until the consumer takes it.
module serial_dot_product
  import serial_dot_product_pkg::*;
#(
  parameter int unsigned  DATA_W = 8,
  parameter int unsigned  LEN    = 3,
  parameter int unsigned  SIGNED = 0,
  localparam int unsigned OUT_W  = out_width(DATA_W, LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [OUT_W-1:0]  dout,
  output logic              dout_valid,
  input  logic              dout_ready
);

  localparam int unsigned      IDX_W    = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LEN - 1);

  sdp_state_t            state_q;
  sdp_state_t            state_d;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      idx_d;
  logic [OUT_W-1:0]      acc_q;
  logic [OUT_W-1:0]      acc_d;
  logic [OUT_W-1:0]      dout_d;
  logic                  dout_valid_d;
  logic                  a_we;
  logic                  in_xfer;
  logic                  out_xfer;
  logic [LEN*DATA_W-1:0] a_buf;
  logic [DATA_W-1:0]     a_sel;
  logic [OUT_W-1:0]      prod;

  assign in_xfer  = din_valid && din_ready;
  assign out_xfer = dout_valid && dout_ready;
  assign a_sel    = a_buf[32'(idx_q) * DATA_W +: DATA_W];

  sdp_mul_ext #(
    .DATA_W (DATA_W),
    .SIGNED (SIGNED),
    .OUT_W  (OUT_W)
  ) u_mul (
    .a   (a_sel),
    .b   (din),
    .p_c (prod)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath update selection.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    dout_d       = dout;
    dout_valid_d = dout_valid;
    a_we         = 1'b0;

    case (state_q)
      LOAD_A: begin
        if (in_xfer) begin
          a_we = 1'b1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            acc_d   = '0;
            state_d = MAC_B;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      MAC_B: begin
        if (in_xfer) begin
          if (idx_q == IDX_LAST) begin
            dout_d       = acc_q + prod;
            dout_valid_d = 1'b1;
            idx_d        = '0;
            state_d      = OUT;
          end else begin
            acc_d = acc_q + prod;
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      OUT: begin
        if (out_xfer) begin
          dout_valid_d = 1'b0;
          state_d      = LOAD_A;
        end
      end
      default: begin
        state_d = LOAD_A;
        idx_d   = '0;
      end
    endcase
  end

  // Datapath registers; din_ready tracks the next state so it is a clean flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q      <= '0;
      acc_q      <= '0;
      a_buf      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      din_ready  <= 1'b1;
    end else begin
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      dout       <= dout_d;
      dout_valid <= dout_valid_d;
      din_ready  <= (state_d != OUT);
      if (a_we) begin
        a_buf[32'(idx_q) * DATA_W +: DATA_W] <= din;
      end
    end
  end

endmodule

// File: tb/tb_serial_dot_product.sv
// Bench for serial_dot_product: unsigned and signed LEN=3 instances share one
// input stream; a LEN=1 instance has its own.
module tb_serial_dot_product;

  localparam int unsigned DW  = 8;
  localparam int unsigned OW  = 18;
  localparam int unsigned OW1 = 17;

  typedef logic [DW-1:0] vec_t [6];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          dout_ready;
  logic          din_ready,  din_ready_s;
  logic [OW-1:0] dout,       dout_s;
  logic          dout_valid, dout_valid_s;

  logic [DW-1:0]  din1;
  logic           din1_valid;
  logic           dout1_ready;
  logic           din1_ready;
  logic [OW1-1:0] dout1;
  logic           dout1_valid;

  int n_vec = 0;
  int n_err = 0;

  serial_dot_product #(.DATA_W(8), .LEN(3), .SIGNED(0)) u_dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready));

  serial_dot_product #(.DATA_W(8), .LEN(3), .SIGNED(1)) u_dut_s (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready_s),
    .dout(dout_s), .dout_valid(dout_valid_s), .dout_ready(dout_ready));

  serial_dot_product #(.DATA_W(8), .LEN(1), .SIGNED(0)) u_dut1 (
    .clk(clk), .reset(reset), .din(din1), .din_valid(din1_valid), .din_ready(din1_ready),
    .dout(dout1), .dout_valid(dout1_valid), .dout_ready(dout1_ready));

  // Reference: sum of a[i]*b[i] over the 6-word stream, elements unsigned.
  function automatic logic [OW-1:0] ref_unsigned(input vec_t v);
    longint s = 0;
    for (int i = 0; i < 3; i++) s += longint'(v[i]) * longint'(v[i+3]);
    return OW'(s);
  endfunction

  // Reference: same sum with elements read as two's complement.
  function automatic logic [OW-1:0] ref_signed(input vec_t v);
    longint s = 0;
    for (int i = 0; i < 3; i++) s += longint'($signed(v[i])) * longint'($signed(v[i+3]));
    return OW'(s);
  endfunction

  // Present one word, optionally preceded by idle cycles; returns after its transfer.
  task automatic drive_word(input logic [DW-1:0] w, input int gap_pct);
    int budget;
    budget = 0;
    while (($urandom_range(99) < gap_pct) && budget < 8) begin
      din_valid = 1'b0;
      din = DW'($urandom);
      @(negedge clk);
      budget++;
    end
    din = w;
    din_valid = 1'b1;
    budget = 0;
    while (din_ready !== 1'b1 && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    if (din_ready !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL drive_word: din_ready got %b want 1 (timeout)", din_ready);
    end
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic feed_vec(input vec_t v, input int gap_pct);
    for (int k = 0; k < 6; k++) drive_word(v[k], gap_pct);
  endtask

  // Bounded wait for a result on the shared-stream instances.
  task automatic wait_result(input string tag);
    int budget;
    budget = 0;
    while (dout_valid !== 1'b1 && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    n_vec++;
    if (dout_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s: dout_valid got %b want 1 (timeout)", tag, dout_valid);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; din_valid = 1'b0; din = '0; dout_ready = 1'b0;
    din1_valid = 1'b0; din1 = '0; dout1_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if (din_ready !== 1'b1 || dout_valid !== 1'b0 || dout !== '0) begin
      n_err++;
      $display("FAIL reset: ready/valid/dout got %b/%b/%h want 1/0/0", din_ready, dout_valid, dout);
    end
    n_vec++;
    if (din_ready_s !== 1'b1 || dout_valid_s !== 1'b0 || dout_s !== '0) begin
      n_err++;
      $display("FAIL reset_signed: ready/valid/dout got %b/%b/%h want 1/0/0", din_ready_s, dout_valid_s, dout_s);
    end
    n_vec++;
    if (din1_ready !== 1'b1 || dout1_valid !== 1'b0 || dout1 !== '0) begin
      n_err++;
      $display("FAIL reset_len1: ready/valid/dout got %b/%b/%h want 1/0/0", din1_ready, dout1_valid, dout1);
    end
  endtask

  task automatic test_back_to_back;
    vec_t v1, v2;
    logic [OW-1:0] exp_u, exp_s;
    v1 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    for (int k = 0; k < 6; k++) v2[k] = DW'($urandom);
    dout_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      din = v1[k]; din_valid = 1'b1;
      n_vec++;
      if (din_ready !== 1'b1) begin
        n_err++; $display("FAIL b2b_ready_v1[%0d]: got %b want 1", k, din_ready);
      end
      @(negedge clk);
    end
    exp_u = ref_unsigned(v1);
    n_vec++;
    if (dout_valid !== 1'b1 || dout !== exp_u || din_ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_first: valid/dout/ready got %b/%0d/%b want 1/%0d/0", dout_valid, dout, din_ready, exp_u);
    end
    din = v2[0]; din_valid = 1'b1;
    @(negedge clk);
    n_vec++;
    if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_turnaround: valid/ready got %b/%b want 0/1", dout_valid, din_ready);
    end
    for (int k = 0; k < 6; k++) begin
      din = v2[k]; din_valid = 1'b1;
      n_vec++;
      if (din_ready !== 1'b1) begin
        n_err++; $display("FAIL b2b_ready_v2[%0d]: got %b want 1", k, din_ready);
      end
      @(negedge clk);
    end
    din_valid = 1'b0;
    exp_u = ref_unsigned(v2);
    exp_s = ref_signed(v2);
    n_vec++;
    if (dout_valid !== 1'b1 || dout !== exp_u) begin
      n_err++;
      $display("FAIL b2b_second: valid/dout got %b/%0d want 1/%0d", dout_valid, dout, exp_u);
    end
    n_vec++;
    if (dout_valid_s !== 1'b1 || dout_s !== exp_s) begin
      n_err++;
      $display("FAIL b2b_second_signed: valid/dout got %b/%h want 1/%h", dout_valid_s, dout_s, exp_s);
    end
    @(negedge clk);
  endtask

  task automatic test_directed;
    vec_t tbl [4];
    logic [OW-1:0] exp_u, exp_s;
    tbl[0] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    tbl[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[2] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h7F, 8'hFF};
    tbl[3] = '{8'h7F, 8'hFF, 8'h00, 8'hFF, 8'h05, 8'h63};
    dout_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      exp_u = ref_unsigned(tbl[t]);
      exp_s = ref_signed(tbl[t]);
      feed_vec(tbl[t], 0);
      wait_result("directed");
      n_vec++;
      if (dout !== exp_u) begin
        n_err++; $display("FAIL directed_unsigned[%0d]: got %h want %h", t, dout, exp_u);
      end
      n_vec++;
      if (dout_valid_s !== 1'b1 || dout_s !== exp_s) begin
        n_err++; $display("FAIL directed_signed[%0d]: got %b/%h want 1/%h", t, dout_valid_s, dout_s, exp_s);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    vec_t v1, v2;
    logic [OW-1:0] exp_u;
    v1 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    v2 = '{8'd7, 8'd8, 8'd9, 8'd1, 8'd2, 8'd3};
    exp_u = ref_unsigned(v1);
    dout_ready = 1'b0;
    feed_vec(v1, 0);
    wait_result("backpressure");
    for (int c = 0; c < 10; c++) begin
      din = DW'($urandom); din_valid = 1'b1;
      n_vec++;
      if (dout_valid !== 1'b1 || dout !== exp_u || din_ready !== 1'b0) begin
        n_err++;
        $display("FAIL stall[%0d]: valid/dout/ready got %b/%0d/%b want 1/%0d/0", c, dout_valid, dout, din_ready, exp_u);
      end
      @(negedge clk);
    end
    dout_ready = 1'b1;
    din = v2[0]; din_valid = 1'b1;
    @(negedge clk);
    n_vec++;
    if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin
      n_err++;
      $display("FAIL stall_release: valid/ready got %b/%b want 0/1", dout_valid, din_ready);
    end
    exp_u = ref_unsigned(v2);
    feed_vec(v2, 0);
    wait_result("after_stall");
    n_vec++;
    if (dout !== exp_u) begin
      n_err++; $display("FAIL after_stall: got %0d want %0d", dout, exp_u);
    end
    @(negedge clk);
  endtask

  task automatic test_gaps;
    vec_t v;
    logic [OW-1:0] exp_u, first;
    v = '{8'd2, 8'd0, 8'd7, 8'd3, 8'd9, 8'd1};
    exp_u = ref_unsigned(v);
    dout_ready = 1'b1;
    feed_vec(v, 0);
    wait_result("gapfree");
    first = dout;
    n_vec++;
    if (dout !== exp_u) begin
      n_err++; $display("FAIL gapfree: got %0d want %0d", dout, exp_u);
    end
    @(negedge clk);
    feed_vec(v, 50);
    wait_result("gapped");
    n_vec++;
    if (dout !== exp_u || dout !== first) begin
      n_err++; $display("FAIL gapped: got %0d want %0d", dout, exp_u);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    vec_t v;
    logic [OW-1:0] exp_u, exp_s;
    for (int t = 0; t < 25; t++) begin
      for (int k = 0; k < 6; k++) v[k] = DW'($urandom);
      exp_u = ref_unsigned(v);
      exp_s = ref_signed(v);
      dout_ready = 1'b0;
      feed_vec(v, 40);
      wait_result("random");
      repeat ($urandom_range(3)) @(negedge clk);
      n_vec++;
      if (dout_valid !== 1'b1 || dout !== exp_u) begin
        n_err++; $display("FAIL random_unsigned[%0d]: got %b/%h want 1/%h", t, dout_valid, dout, exp_u);
      end
      n_vec++;
      if (dout_valid_s !== 1'b1 || dout_s !== exp_s) begin
        n_err++; $display("FAIL random_signed[%0d]: got %b/%h want 1/%h", t, dout_valid_s, dout_s, exp_s);
      end
      dout_ready = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    vec_t v;
    logic [OW-1:0] exp_u;
    dout_ready = 1'b1;
    for (int k = 0; k < 4; k++) drive_word(DW'(k + 1), 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if (dout_valid !== 1'b0 || din_ready !== 1'b1 || dout !== '0) begin
      n_err++;
      $display("FAIL reset_mid: valid/ready/dout got %b/%b/%h want 0/1/0", dout_valid, din_ready, dout);
    end
    v = '{8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2};
    exp_u = ref_unsigned(v);
    feed_vec(v, 0);
    wait_result("reset_mid_after");
    n_vec++;
    if (dout !== exp_u) begin
      n_err++; $display("FAIL reset_mid_after: got %0d want %0d", dout, exp_u);
    end
    dout_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (dout_valid !== 1'b1) begin
      n_err++; $display("FAIL reset_out_hold: got %b want 1", dout_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_out: valid/ready got %b/%b want 0/1", dout_valid, din_ready);
    end
    dout_ready = 1'b1;
  endtask

  task automatic test_len1;
    logic [DW-1:0]  a, b;
    logic [OW1-1:0] exp1;
    dout1_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      a = (t == 0) ? DW'(9) : DW'($urandom);
      b = (t == 0) ? DW'(9) : DW'($urandom);
      exp1 = OW1'(int'(a) * int'(b));
      din1 = a; din1_valid = 1'b1;
      n_vec++;
      if (din1_ready !== 1'b1) begin
        n_err++; $display("FAIL len1_ready_a[%0d]: got %b want 1", t, din1_ready);
      end
      @(negedge clk);
      din1 = b;
      n_vec++;
      if (din1_ready !== 1'b1 || dout1_valid !== 1'b0) begin
        n_err++; $display("FAIL len1_ready_b[%0d]: ready/valid got %b/%b want 1/0", t, din1_ready, dout1_valid);
      end
      @(negedge clk);
      din1_valid = 1'b0;
      n_vec++;
      if (dout1_valid !== 1'b1 || dout1 !== exp1 || din1_ready !== 1'b0) begin
        n_err++;
        $display("FAIL len1_result[%0d]: valid/dout/ready got %b/%0d/%b want 1/%0d/0", t, dout1_valid, dout1, din1_ready, exp1);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    din = '0; din_valid = 1'b0; dout_ready = 1'b0;
    din1 = '0; din1_valid = 1'b0; dout1_ready = 1'b0;
    @(negedge clk);
    test_reset;
    test_back_to_back;
    test_directed;
    test_backpressure;
    test_gaps;
    test_random;
    test_reset_mid;
    test_len1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
